// File: rtl/bus_master_if_pkg.sv
// Shared definitions for the CPU-side bus master interface: state
// encodings, transfer direction and active-low strobe polarities.
package bus_master_if_pkg;

  typedef enum logic [1:0] {
    BUS_IF_STATE_IDLE   = 2'd0,
    BUS_IF_STATE_REQ    = 2'd1,
    BUS_IF_STATE_ACCESS = 2'd2,
    BUS_IF_STATE_STALL  = 2'd3
  } bus_if_state_e;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // True when an active-low strobe is asserted.
  function automatic logic is_enabled(input logic sig_);
    return sig_ == ENABLE_;
  endfunction

endpackage

// File: rtl/bus_if_tmo.sv
// Bus timeout counter. Counts ready-less ACCESS cycles and flags the
// cycle on which the count reaches TIMEOUT. The count saturates and is
// cleared whenever the master is not going to be in ACCESS next cycle.
// With TIMEOUT=0 the counter does not exist and expire is tied low.
module bus_if_tmo #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    logic tie_unused;
    assign tie_unused = clk ^ reset ^ clr ^ en;
    assign expire     = 1'b0;
  end else begin : g_on
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // Count ready-less cycles; saturate at the limit, clear on request.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
      end else if (clr) begin
        cnt <= '0;
      end else if (en && cnt != LIMIT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    // Expire on the cycle whose increment would reach the limit.
    assign expire = en && (cnt == LAST);
  end

endmodule

// File: rtl/bus_master_if.sv
// CPU-side bus master interface. Steers each CPU access either to the
// scratch-pad memory (zero wait) or to the shared bus via a
// request/grant/strobe/ready handshake. Bus writes may be posted so the
// CPU continues while the write drains; SPM hits are still served while
// a posted write is in flight. A hung transfer is aborted after TIMEOUT
// ready-less ACCESS cycles and reported with a one-cycle err pulse.
//
// Handshake: the master holds bus_req_ low from the cycle after the
// access is accepted until the completing cycle; bus_as_ is low for the
// first ACCESS cycle only; a transfer completes on the first ACCESS
// cycle that sees bus_rdy_ low. On the CPU side an access presented with
// as_ low is consumed on the first cycle in which busy is low.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 3,
  parameter int SPM_INDEX = 1,
  parameter int POSTED_WR = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  output logic                busy,
  output logic                err,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                as_,
  input  logic                rw,
  input  logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data,
  input  logic [DATA_W-1:0]   spm_rd_data,
  output logic [ADDR_W-1:0]   spm_addr,
  output logic                spm_as_,
  output logic                spm_rw,
  output logic [DATA_W-1:0]   spm_wr_data,
  input  logic [DATA_W-1:0]   bus_rd_data,
  input  logic                bus_rdy_,
  input  logic                bus_grnt_,
  output logic                bus_req_,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_as_,
  output logic                bus_rw,
  output logic [DATA_W-1:0]   bus_wr_data,
  output bus_if_state_e       state
);

  bus_if_state_e     state_n;
  logic              posted, posted_n;
  logic              bus_req_n, bus_as_n, bus_rw_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [DATA_W-1:0] bus_wr_data_n;
  logic [DATA_W-1:0] rd_buf, rd_buf_n;
  logic              err_n;
  logic              release_bus;

  logic accept, is_spm, spm_hit, bus_hit, spm_ok;
  logic tmo_clr, tmo_en, tmo_expire;

  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  assign accept  = !flush && is_enabled(as_);
  assign is_spm  = addr[ADDR_W-1 -: IDX_W] == IDX_W'(SPM_INDEX);
  assign spm_hit = accept && is_spm;
  assign bus_hit = accept && !is_spm;
  // SPM stays reachable while only a posted write occupies the bus.
  assign spm_ok  = (state == BUS_IF_STATE_IDLE) ||
                   (posted && (state == BUS_IF_STATE_REQ ||
                               state == BUS_IF_STATE_ACCESS));

  assign tmo_en  = (state == BUS_IF_STATE_ACCESS) && !is_enabled(bus_rdy_);
  assign tmo_clr = (state_n != BUS_IF_STATE_ACCESS);

  bus_if_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // State and bus-side registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BUS_IF_STATE_IDLE;
      posted      <= 1'b0;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_buf      <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_n;
      posted      <= posted_n;
      bus_req_    <= bus_req_n;
      bus_as_     <= bus_as_n;
      bus_rw      <= bus_rw_n;
      bus_addr    <= bus_addr_n;
      bus_wr_data <= bus_wr_data_n;
      rd_buf      <= rd_buf_n;
      err         <= err_n;
    end
  end

  // Next-state, bus control and CPU-side responses.
  always_comb begin
    state_n       = state;
    posted_n      = posted;
    bus_req_n     = bus_req_;
    bus_as_n      = DISABLE_;
    bus_rw_n      = bus_rw;
    bus_addr_n    = bus_addr;
    bus_wr_data_n = bus_wr_data;
    rd_buf_n      = rd_buf;
    err_n         = 1'b0;
    rd_data       = '0;
    spm_as_       = DISABLE_;
    busy          = 1'b0;
    release_bus   = 1'b0;

    if (spm_hit && spm_ok && !stall) begin
      spm_as_ = ENABLE_;
      if (rw == READ) rd_data = spm_rd_data;
    end

    case (state)
      BUS_IF_STATE_IDLE: begin
        if (bus_hit) begin
          bus_addr_n    = addr;
          bus_rw_n      = rw;
          bus_wr_data_n = wr_data;
          bus_req_n     = ENABLE_;
          state_n       = BUS_IF_STATE_REQ;
          if (rw == WRITE && POSTED_WR != 0) begin
            posted_n = 1'b1;
          end else begin
            posted_n = 1'b0;
            busy     = 1'b1;
          end
        end
      end
      BUS_IF_STATE_REQ: begin
        busy = !posted || bus_hit;
        if (is_enabled(bus_grnt_)) begin
          state_n  = BUS_IF_STATE_ACCESS;
          bus_as_n = ENABLE_;
        end
      end
      BUS_IF_STATE_ACCESS: begin
        if (is_enabled(bus_rdy_)) begin
          release_bus = 1'b1;
          busy        = posted && bus_hit;
          if (bus_rw == READ) begin
            rd_buf_n = bus_rd_data;
            rd_data  = bus_rd_data;
          end
        end else if (tmo_expire) begin
          // Abort: read data forced to zero, error reported next cycle.
          release_bus = 1'b1;
          rd_buf_n    = '0;
          busy        = posted && bus_hit;
          err_n       = 1'b1;
        end else begin
          busy = !posted || bus_hit;
        end
      end
      BUS_IF_STATE_STALL: begin
        if (rw == READ) rd_data = rd_buf;
        if (!stall) state_n = BUS_IF_STATE_IDLE;
      end
      default: state_n = BUS_IF_STATE_IDLE;
    endcase

    if (release_bus) begin
      bus_req_n     = DISABLE_;
      bus_addr_n    = '0;
      bus_rw_n      = READ;
      bus_wr_data_n = '0;
      if (posted) begin
        // A posted write has no CPU waiting on it, so stall is irrelevant.
        posted_n = 1'b0;
        state_n  = BUS_IF_STATE_IDLE;
      end else begin
        state_n = stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: a bus slave responder with per-transfer grant
// and ready delays, CPU driver tasks, and feature tests whose expected
// latencies come from the cycle-count rules of the interface.
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int T  = 4;

  logic          clk, reset, stall, flush, busy, err;
  logic [AW-1:0] addr;
  logic          as_, rw;
  logic [DW-1:0] wr_data, rd_data, spm_rd_data;
  logic [AW-1:0] spm_addr;
  logic          spm_as_, spm_rw;
  logic [DW-1:0] spm_wr_data;
  logic [DW-1:0] bus_rd_data;
  logic          bus_rdy_, bus_grnt_, bus_req_;
  logic [AW-1:0] bus_addr;
  logic          bus_as_, bus_rw;
  logic [DW-1:0] bus_wr_data;
  bus_if_state_e state;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Slave response parameters, one entry per bus transfer in bus order.
  int            sl_g[$];
  int            sl_r[$];
  logic [DW-1:0] sl_d[$];

  bus_master_if #(
    .ADDR_W(AW), .DATA_W(DW), .IDX_W(3), .SPM_INDEX(1),
    .POSTED_WR(1), .TIMEOUT(T)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .busy(busy), .err(err), .addr(addr), .as_(as_), .rw(rw),
    .wr_data(wr_data), .rd_data(rd_data), .spm_rd_data(spm_rd_data),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_), .bus_req_(bus_req_),
    .bus_addr(bus_addr), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_wr_data(bus_wr_data), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bus slave ----------------
  initial begin : slave
    int cnt, cg, cr;
    bit active, granted;
    logic [DW-1:0] cd;
    cnt = 0; cg = 0; cr = 0; cd = '0; active = 0; granted = 0;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    forever begin
      @(negedge clk);
      if (bus_req_ !== 1'b0) begin
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; active = 0;
      end else begin
        if (!active) begin
          active = 1; granted = 0; cnt = 0;
          if (sl_g.size() > 0) begin
            cg = sl_g.pop_front(); cr = sl_r.pop_front(); cd = sl_d.pop_front();
          end else begin
            cg = 0; cr = 0; cd = '0;
          end
        end
        if (!granted) begin
          if (cnt == cg) begin bus_grnt_ = 1'b0; granted = 1; cnt = 0; end
          else cnt++;
        end else begin
          bus_rdy_ = (cnt == cr) ? 1'b0 : 1'b1;
          bus_rd_data = cd;
          cnt++;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Last busy cycle of a bus transfer accepted in cycle s: one IDLE
  // cycle, g+1 REQ cycles, then ACCESS until ready or the timeout.
  function automatic int bus_done(input int s, input int g, input int r);
    return s + g + 1 + ((r + 1 < T) ? r + 1 : T);
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int idx);
    logic [AW-1:0] a;
    a = AW'($urandom);
    a[AW-1 -: 3] = 3'(idx);
    return a;
  endfunction

  function automatic int bus_idx();
    int i;
    i = $urandom_range(0, 6);
    if (i >= 1) i++;
    return i;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_slave(input int g, input int r, input logic [DW-1:0] d);
    sl_g.push_back(g); sl_r.push_back(r); sl_d.push_back(d);
  endtask

  // Present an access and hold it until busy drops (bounded).
  task automatic cpu_access(input logic rw_i, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, output int t0,
                            output int done, output logic [DW-1:0] rdat,
                            output logic sas);
    bit got;
    got = 0; done = -1; rdat = '0; sas = 1'b1;
    @(negedge clk);
    t0 = cyc; as_ = 1'b0; addr = a; rw = rw_i; wr_data = wd;
    for (int k = 0; k < 64 && !got; k++) begin
      if (k > 0) @(negedge clk);
      #2;
      if (busy === 1'b0) begin
        got = 1; done = cyc; rdat = rd_data; sas = spm_as_;
      end
    end
  endtask

  task automatic cpu_idle();
    @(negedge clk);
    as_ = 1'b1; flush = 1'b0;
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = READ;
    addr = '0; wr_data = '0; spm_rd_data = '0;
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if ({bus_req_, bus_as_, bus_rw, err, busy, spm_as_} !== 6'b111001)
      $display("FAIL reset_ctrl: got %b want 111001",
               {bus_req_, bus_as_, bus_rw, err, busy, spm_as_});
    else n_pass++;
    n_checks++;
    if (bus_addr !== '0 || bus_wr_data !== '0)
      $display("FAIL reset_bus: addr %h data %h want 0", bus_addr, bus_wr_data);
    else n_pass++;
    n_checks++;
    if (rd_data !== '0) $display("FAIL reset_rd_data: got %h want 0", rd_data);
    else n_pass++;
    n_checks++;
    if (state !== BUS_IF_STATE_IDLE) $display("FAIL reset_state: got %0d want 0", state);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_spm_read();
    int t0, done;
    logic [DW-1:0] rdat;
    logic sas;
    logic [AW-1:0] a;
    a = mk_addr(1);
    spm_rd_data = 32'hDEADBEEF;
    cpu_access(READ, a, '0, t0, done, rdat, sas);
    n_checks++;
    if (done !== t0) $display("FAIL spm_read_wait: done %0d want %0d", done, t0);
    else n_pass++;
    n_checks++;
    if (rdat !== 32'hDEADBEEF || sas !== 1'b0)
      $display("FAIL spm_read_data: got %h/%b want deadbeef/0", rdat, sas);
    else n_pass++;
    n_checks++;
    if (spm_addr !== a) $display("FAIL spm_addr: got %h want %h", spm_addr, a);
    else n_pass++;
    // Stalled SPM access must not strobe the SPM.
    @(negedge clk);
    stall = 1'b1;
    #2;
    n_checks++;
    if (spm_as_ !== 1'b1) $display("FAIL spm_stall: spm_as_ %b want 1", spm_as_);
    else n_pass++;
    @(negedge clk);
    stall = 1'b0;
    cpu_idle();
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1; as_ = 1'b0; rw = READ; addr = mk_addr(2);
    #2;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy);
    else n_pass++;
    @(negedge clk);
    addr = mk_addr(1);
    #2;
    n_checks++;
    if (spm_as_ !== 1'b1 || bus_req_ !== 1'b1)
      $display("FAIL flush_ignored: spm_as_ %b bus_req_ %b want 1/1", spm_as_, bus_req_);
    else n_pass++;
    cpu_idle();
  endtask

  task automatic test_bus_read();
    int t0, done;
    logic [DW-1:0] rdat;
    logic sas;
    push_slave(2, 3, 32'h12345678);
    cpu_access(READ, mk_addr(2), '0, t0, done, rdat, sas);
    n_checks++;
    if (done - t0 !== 7) $display("FAIL bus_read_latency: got %0d want 7", done - t0);
    else n_pass++;
    n_checks++;
    if (rdat !== 32'h12345678) $display("FAIL bus_read_data: got %h want 12345678", rdat);
    else n_pass++;
    cpu_idle();
    n_checks++;
    if (bus_req_ !== 1'b1 || err !== 1'b0)
      $display("FAIL bus_read_release: req_ %b err %b want 1/0", bus_req_, err);
    else n_pass++;
  endtask

  task automatic test_posted_write();
    int t0, done, w0, seen;
    logic [DW-1:0] rdat, sd, s_wd;
    logic sas, s_rw;
    logic [AW-1:0] wa, s_a;
    wa = mk_addr(3);
    push_slave(5, 0, '0);
    cpu_access(WRITE, wa, 32'h0000CAFE, t0, done, rdat, sas);
    w0 = t0;
    n_checks++;
    if (done !== t0) $display("FAIL posted_wr_busy: done %0d want %0d", done, t0);
    else n_pass++;
    sd = $urandom;
    spm_rd_data = sd;
    cpu_access(READ, mk_addr(1), '0, t0, done, rdat, sas);
    n_checks++;
    if (done !== t0 || rdat !== sd || sas !== 1'b0)
      $display("FAIL posted_spm_read: wait %0d data %h/%b want 0 %h/0", done - t0, rdat, sas, sd);
    else n_pass++;
    seen = -1; s_rw = READ; s_wd = '0; s_a = '0;
    for (int k = 0; k < 20; k++) begin
      cpu_idle();
      if (bus_as_ === 1'b0 && seen < 0) begin
        seen = cyc; s_rw = bus_rw; s_wd = bus_wr_data; s_a = bus_addr;
      end
    end
    n_checks++;
    if (seen !== w0 + 7) $display("FAIL posted_wr_strobe: cycle %0d want %0d", seen - w0, 7);
    else n_pass++;
    n_checks++;
    if (s_rw !== WRITE || s_wd !== 32'h0000CAFE || s_a !== wa)
      $display("FAIL posted_wr_bus: rw %b data %h addr %h want 0 cafe %h", s_rw, s_wd, s_a, wa);
    else n_pass++;
  endtask

  task automatic test_posted_then_read();
    int t0, done, w0;
    logic [DW-1:0] rdat, d;
    logic sas;
    d = $urandom;
    push_slave(1, 2, '0);
    push_slave(0, 0, d);
    cpu_access(WRITE, mk_addr(4), $urandom, t0, done, rdat, sas);
    w0 = t0;
    cpu_access(READ, mk_addr(5), '0, t0, done, rdat, sas);
    n_checks++;
    if (done !== bus_done(bus_done(w0, 1, 2) + 1, 0, 0))
      $display("FAIL posted_then_read_wait: done %0d want %0d", done - w0,
               bus_done(bus_done(w0, 1, 2) + 1, 0, 0) - w0);
    else n_pass++;
    n_checks++;
    if (rdat !== d) $display("FAIL posted_then_read_data: got %h want %h", rdat, d);
    else n_pass++;
    cpu_idle();
  endtask

  task automatic test_timeout();
    int t0, done;
    logic [DW-1:0] rdat;
    logic sas;
    push_slave(0, 99, 32'hAAAA5555);
    cpu_access(READ, mk_addr(6), '0, t0, done, rdat, sas);
    n_checks++;
    if (done - t0 !== 1 + 1 + T - 1 + 1 - 1 + 0 + 1 - 1 + 0 + 1 - 1 + 1 - 1 + (0))
      $display("FAIL timeout_latency: got %0d want %0d", done - t0, T + 1);
    else n_pass++;
    n_checks++;
    if (rdat !== '0) $display("FAIL timeout_rd_data: got %h want 0", rdat);
    else n_pass++;
    cpu_idle();
    n_checks++;
    if (err !== 1'b1 || bus_req_ !== 1'b1)
      $display("FAIL timeout_err: err %b req_ %b want 1/1", err, bus_req_);
    else n_pass++;
    cpu_idle();
    n_checks++;
    if (err !== 1'b0) $display("FAIL timeout_err_pulse: err %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_stall();
    int t0, done;
    logic [DW-1:0] rdat, d;
    logic sas;
    d = $urandom;
    push_slave(0, 0, d);
    stall = 1'b1;
    cpu_access(READ, mk_addr(2), '0, t0, done, rdat, sas);
    n_checks++;
    if (done - t0 !== 2 || rdat !== d)
      $display("FAIL stall_read: wait %0d data %h want 2 %h", done - t0, rdat, d);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 2) stall = 1'b0;
      #2;
      n_checks++;
      if (rd_data !== d || state !== BUS_IF_STATE_STALL || busy !== 1'b0)
        $display("FAIL stall_hold: rd %h state %0d busy %b want %h 3 0", rd_data, state, busy, d);
      else n_pass++;
    end
    cpu_idle();
    n_checks++;
    if (state !== BUS_IF_STATE_IDLE) $display("FAIL stall_exit: state %0d want 0", state);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    push_slave(0, 99, '0);
    @(negedge clk);
    as_ = 1'b0; rw = READ; addr = mk_addr(7);
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if (bus_as_ !== 1'b0) $display("FAIL reset_mid_pre: bus_as_ %b want 0", bus_as_);
    else n_pass++;
    #1;
    reset = 1'b0; as_ = 1'b1;
    #1;
    n_checks++;
    if ({bus_req_, bus_as_, bus_rw, busy} !== 4'b1110 || bus_addr !== '0 ||
        state !== BUS_IF_STATE_IDLE)
      $display("FAIL reset_mid: ctrl %b addr %h state %0d want 1110 0 0",
               {bus_req_, bus_as_, bus_rw, busy}, bus_addr, state);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    cpu_idle();
  endtask

  task automatic test_random();
    int t0, done, kind, g, r, s, wr_end, exp_done;
    logic [DW-1:0] rdat, d;
    logic sas;
    wr_end = -100;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      g = $urandom_range(0, 3);
      r = $urandom_range(0, 5);
      d = $urandom;
      case (kind)
        0: begin
          spm_rd_data = d;
          cpu_access(READ, mk_addr(1), '0, t0, done, rdat, sas);
          n_checks++;
          if (done !== t0 || rdat !== d || sas !== 1'b0)
            $display("FAIL rand_spm_rd %0d: wait %0d data %h/%b want 0 %h/0", n, done - t0, rdat, sas, d);
          else n_pass++;
        end
        1: begin
          cpu_access(WRITE, mk_addr(1), d, t0, done, rdat, sas);
          n_checks++;
          if (done !== t0 || sas !== 1'b0 || spm_wr_data !== d || spm_rw !== WRITE)
            $display("FAIL rand_spm_wr %0d: wait %0d as_ %b data %h want 0 0 %h", n, done - t0, sas, spm_wr_data, d);
          else n_pass++;
        end
        2: begin
          push_slave(g, r, d);
          cpu_access(READ, mk_addr(bus_idx()), '0, t0, done, rdat, sas);
          s = (t0 > wr_end + 1) ? t0 : wr_end + 1;
          exp_done = bus_done(s, g, r);
          n_checks++;
          if (done !== exp_done || rdat !== ((r < T) ? d : '0))
            $display("FAIL rand_bus_rd %0d: done +%0d data %h want +%0d %h", n, done - t0, rdat,
                     exp_done - t0, (r < T) ? d : '0);
          else n_pass++;
          cpu_idle();
          n_checks++;
          if (err !== (r >= T)) $display("FAIL rand_bus_err %0d: err %b want %b", n, err, r >= T);
          else n_pass++;
        end
        default: begin
          push_slave(g, r, '0);
          cpu_access(WRITE, mk_addr(bus_idx()), d, t0, done, rdat, sas);
          s = (t0 > wr_end + 1) ? t0 : wr_end + 1;
          n_checks++;
          if (done !== s) $display("FAIL rand_bus_wr %0d: done +%0d want +%0d", n, done - t0, s - t0);
          else n_pass++;
          wr_end = bus_done(s, g, r);
        end
      endcase
    end
    repeat (20) cpu_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_spm_read();
    test_flush();
    test_bus_read();
    test_posted_write();
    test_posted_then_read();
    test_timeout();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
